// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by fetch and the memory stage.
// Data has priority; a starvation counter bounds how long fetch can be held off.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        stall_fetch,
   input  logic        branch_kill,

   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,

   output logic        m_en,
   output logic [3:0]  m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata
);

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      IF_RESP = 2'd1,
      D_RD    = 2'd2,
      D_WR    = 2'd3
   } owner_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   owner_t     owner_q;
   owner_t     owner_d;
   logic [3:0] starve_cnt;
   logic       fetch_turn;

   // Grants: data wins unless fetch has waited STARVE_MAX data grants.
   // A kill only removes the fetch grant, so data may still take the port.
   always_comb begin
      fetch_turn  = (starve_cnt == STARVE_LIM);
      if_gnt      = ~reset & if_req & ~branch_kill & (fetch_turn | ~d_req);
      d_gnt       = ~reset & d_req & ~if_gnt;
      stall_fetch = if_req & ~if_gnt;
   end

   always_comb begin
      m_en    = 1'b0;
      m_we    = '0;
      m_addr  = '0;
      m_wdata = '0;
      if (if_gnt) begin
         m_en   = 1'b1;
         m_addr = if_addr;
      end else if (d_gnt) begin
         m_en    = 1'b1;
         m_we    = d_we ? d_be : 4'b0000;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (if_gnt || !if_req) begin
         starve_cnt <= '0;
      end else if (d_gnt && starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q <= NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   always_comb begin
      owner_d = NONE;
      if (if_gnt) begin
         owner_d = IF_RESP;
      end else if (d_gnt) begin
         owner_d = d_we ? D_WR : D_RD;
      end
   end

   // A kill in the response cycle suppresses the fetch word before decode.
   always_comb begin
      if_rvalid = 1'b0;
      if_rdata  = '0;
      d_rvalid  = 1'b0;
      d_rdata   = '0;
      unique case (owner_q)
         IF_RESP: begin
            if_rvalid = ~branch_kill;
            if_rdata  = branch_kill ? 32'd0 : m_rdata;
         end
         D_RD: begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
         end
         D_WR: begin
            d_rvalid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a per-cycle behavioural model.
module tb_mem_port_arbiter;

   localparam int unsigned SMAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        stall_fetch;
   logic        branch_kill;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en;
   logic [3:0]  m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] bmem    [0:16383];
   logic [31:0] ref_mem [0:16383];

   mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stall_fetch(stall_fetch),
      .branch_kill(branch_kill),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory with byte write enables.
   always @(posedge clk) begin
      if (m_en) begin
         m_rdata <= bmem[m_addr[15:2]];
         for (int b = 0; b < 4; b++)
            if (m_we[b]) bmem[m_addr[15:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = '0; branch_kill = 0;
      d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h9000;
      if_addr = 32'h8000; d_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      n_cmp++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, m_en, stall_fetch} !== 6'b000001) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 000001",
                  {if_gnt, d_gnt, if_rvalid, d_rvalid, m_en, stall_fetch});
      end
      n_cmp++;
      if ({m_we, m_addr, m_wdata, if_rdata, d_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_buses: m_we=%h m_addr=%h m_wdata=%h if_rdata=%h d_rdata=%h want all 0",
                  m_we, m_addr, m_wdata, if_rdata, d_rdata);
      end
      idle_inputs();
      #1;
      n_cmp++;
      if (stall_fetch !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_stall_idle: got %b want 0", stall_fetch);
      end
      tick();
      reset = 0;
      @(negedge clk);
      n_cmp++;
      if ({if_rvalid, d_rvalid} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_first_cycle: rvalids got %b want 00", {if_rvalid, d_rvalid});
      end
      tick();
   endtask

   task automatic test_fetch_alone();
      if_req = 1; if_addr = 32'h8000;
      @(negedge clk);
      n_cmp++;
      if ({if_gnt, d_gnt, stall_fetch, m_en, m_we} !== 8'b1001_0000 ||
          m_addr !== 32'h8000 || m_wdata !== 32'd0) begin
         n_bad++;
         $display("FAIL fetch_grant: flags=%b addr=%h wdata=%h want 10010000 8000 0",
                  {if_gnt, d_gnt, stall_fetch, m_en, m_we}, m_addr, m_wdata);
      end
      tick();
      if_addr = 32'h8004;
      @(negedge clk);
      n_cmp++;
      if ({if_gnt, stall_fetch, if_rvalid} !== 3'b101 || if_rdata !== 32'h0000_0093) begin
         n_bad++;
         $display("FAIL fetch_resp1: flags=%b rdata=%h want 101 00000093",
                  {if_gnt, stall_fetch, if_rvalid}, if_rdata);
      end
      tick();
      if_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({if_rvalid, m_en} !== 2'b10 || if_rdata !== ref_mem[14'h2001]) begin
         n_bad++;
         $display("FAIL fetch_resp2: flags=%b rdata=%h want 10 %h",
                  {if_rvalid, m_en}, if_rdata, ref_mem[14'h2001]);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (if_rvalid !== 1'b0 || if_rdata !== 32'd0) begin
         n_bad++;
         $display("FAIL fetch_idle: rvalid=%b rdata=%h want 0 0", if_rvalid, if_rdata);
      end
      tick();
   endtask

   task automatic test_collision();
      if_req = 1; if_addr = 32'h8000;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h9000; d_wdata = 32'hA5A5_0F0F;
      @(negedge clk);
      n_cmp++;
      if ({if_gnt, d_gnt, stall_fetch, m_en, m_we} !== 8'b0111_0000 ||
          m_addr !== 32'h9000 || m_wdata !== 32'hA5A5_0F0F) begin
         n_bad++;
         $display("FAIL collide_grant: flags=%b addr=%h wdata=%h want 01110000 9000 a5a50f0f",
                  {if_gnt, d_gnt, stall_fetch, m_en, m_we}, m_addr, m_wdata);
      end
      tick();
      d_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({d_rvalid, if_gnt, stall_fetch} !== 3'b110 || d_rdata !== 32'hDEAD_BEEF ||
          m_addr !== 32'h8000) begin
         n_bad++;
         $display("FAIL collide_resp: flags=%b d_rdata=%h m_addr=%h want 110 deadbeef 8000",
                  {d_rvalid, if_gnt, stall_fetch}, d_rdata, m_addr);
      end
      tick();
      if_req = 0;
      @(negedge clk);
      n_cmp++;
      if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 32'h0000_0093) begin
         n_bad++;
         $display("FAIL collide_fetch: flags=%b if_rdata=%h want 10 00000093",
                  {if_rvalid, d_rvalid}, if_rdata);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_starvation();
      logic want_if;
      logic prev_if = 1'b0;
      if_req = 1; if_addr = 32'h8000;
      d_req = 1; d_we = 0; d_addr = 32'h9000;
      for (int k = 1; k <= 2 * (SMAX + 1); k++) begin
         want_if = (k % (SMAX + 1) == 0);
         @(negedge clk);
         n_cmp++;
         if ({if_gnt, d_gnt, stall_fetch} !== {want_if, ~want_if, ~want_if}) begin
            n_bad++;
            $display("FAIL starve_cycle%0d: gnt/stall got %b want %b", k,
                     {if_gnt, d_gnt, stall_fetch}, {want_if, ~want_if, ~want_if});
         end
         if (k > 1) begin
            n_cmp++;
            if ({if_rvalid, d_rvalid} !== {prev_if, ~prev_if}) begin
               n_bad++;
               $display("FAIL starve_resp%0d: rvalids got %b want %b", k,
                        {if_rvalid, d_rvalid}, {prev_if, ~prev_if});
            end
         end
         prev_if = want_if;
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_store();
      d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h9004; d_wdata = 32'h1234_5678;
      @(negedge clk);
      n_cmp++;
      if ({d_gnt, m_en, m_we} !== 6'b11_0011 || m_addr !== 32'h9004 || m_wdata !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL store_grant: flags=%b addr=%h wdata=%h want 110011 9004 12345678",
                  {d_gnt, m_en, m_we}, m_addr, m_wdata);
      end
      ref_mem[14'h2401] = {ref_mem[14'h2401][31:16], 16'h5678};
      tick();
      d_we = 0; d_wdata = 32'h0;
      @(negedge clk);
      n_cmp++;
      if ({d_rvalid, m_we} !== 5'b1_0000 || d_rdata !== 32'd0) begin
         n_bad++;
         $display("FAIL store_resp: flags=%b d_rdata=%h want 10000 0", {d_rvalid, m_we}, d_rdata);
      end
      tick();
      d_req = 0;
      @(negedge clk);
      n_cmp++;
      if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_5678) begin
         n_bad++;
         $display("FAIL store_merge: rvalid=%b d_rdata=%h want 1 cafe5678", d_rvalid, d_rdata);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_branch_kill();
      if_req = 1; if_addr = 32'h8000; branch_kill = 1;
      @(negedge clk);
      n_cmp++;
      if ({if_gnt, stall_fetch, m_en} !== 3'b010) begin
         n_bad++;
         $display("FAIL kill_grant: flags=%b want 010", {if_gnt, stall_fetch, m_en});
      end
      d_req = 1; d_we = 0; d_addr = 32'h9000;
      #1;
      n_cmp++;
      if ({if_gnt, d_gnt, stall_fetch} !== 3'b011) begin
         n_bad++;
         $display("FAIL kill_data_ok: flags=%b want 011", {if_gnt, d_gnt, stall_fetch});
      end
      d_req = 0;
      tick();
      branch_kill = 0; if_req = 0;
      @(negedge clk);
      n_cmp++;
      if (if_rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL kill_no_resp: if_rvalid got %b want 0", if_rvalid);
      end
      tick();
      if_req = 1;
      @(negedge clk);
      n_cmp++;
      if (if_gnt !== 1'b1) begin
         n_bad++;
         $display("FAIL kill_regrant: if_gnt got %b want 1", if_gnt);
      end
      tick();
      branch_kill = 1;
      @(negedge clk);
      n_cmp++;
      if ({if_rvalid, if_gnt} !== 2'b00 || if_rdata !== 32'd0) begin
         n_bad++;
         $display("FAIL kill_resp_cycle: flags=%b rdata=%h want 00 0", {if_rvalid, if_gnt}, if_rdata);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      n_cmp++;
      if (if_rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL kill_after: if_rvalid got %b want 0", if_rvalid);
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      if_req = 1; if_addr = 32'h8000;
      d_req = 1; d_we = 0; d_addr = 32'h9000;
      for (int k = 0; k < SMAX; k++) tick();
      reset = 1;
      @(negedge clk);
      n_cmp++;
      if ({d_rvalid, if_rvalid, d_gnt, if_gnt, m_en, stall_fetch} !== 6'b000001 ||
          {m_we, m_addr, m_wdata} !== '0) begin
         n_bad++;
         $display("FAIL midreset_outputs: flags=%b m_we=%h m_addr=%h m_wdata=%h want 000001 0 0 0",
                  {d_rvalid, if_rvalid, d_gnt, if_gnt, m_en, stall_fetch}, m_we, m_addr, m_wdata);
      end
      tick();
      reset = 0;
      // Counter must restart from zero: SMAX data grants before fetch wins.
      for (int k = 1; k <= SMAX + 1; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({if_gnt, d_gnt} !== ((k == SMAX + 1) ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL midreset_cycle%0d: gnt got %b want %b", k, {if_gnt, d_gnt},
                     (k == SMAX + 1) ? 2'b10 : 2'b01);
         end
         if (k == 1) begin
            n_cmp++;
            if ({if_rvalid, d_rvalid} !== 2'b00) begin
               n_bad++;
               $display("FAIL midreset_no_resp: rvalids got %b want 00", {if_rvalid, d_rvalid});
            end
         end
         if (k == 2) begin
            n_cmp++;
            if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
               n_bad++;
               $display("FAIL midreset_resume: rvalid=%b rdata=%h want 1 deadbeef", d_rvalid, d_rdata);
            end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      int          waits = 0;
      int          pend_kind = 0;   // 0 none, 1 fetch, 2 load, 3 store
      logic [31:0] pend_data = '0;
      logic        d_hold = 1'b0;
      logic        e_ig, e_dg, e_iv, e_dv;
      logic [3:0]  e_we;
      logic [31:0] e_addr, e_wdata, e_ird, e_drd;
      logic [13:0] idx;
      for (int c = 0; c < 600; c++) begin
         if_req      = ($urandom_range(0, 99) < 70);
         if_addr     = 32'h8000 + ($urandom_range(0, 2047) << 2);
         branch_kill = ($urandom_range(0, 99) < 10);
         if (!d_hold) begin
            d_req   = ($urandom_range(0, 99) < 75);
            d_we    = ($urandom_range(0, 99) < 40);
            d_be    = 4'($urandom);
            d_addr  = 32'h8000 + ($urandom_range(0, 2047) << 2);
            d_wdata = $urandom;
         end
         e_ig  = if_req && !branch_kill && (waits == SMAX || !d_req);
         e_dg  = d_req && !e_ig;
         e_iv  = (pend_kind == 1) && !branch_kill;
         e_dv  = (pend_kind >= 2);
         e_ird = e_iv ? pend_data : 32'd0;
         e_drd = (pend_kind == 2) ? pend_data : 32'd0;
         e_we = '0; e_addr = '0; e_wdata = '0;
         if (e_ig) e_addr = if_addr;
         if (e_dg) begin
            e_addr = d_addr; e_wdata = d_wdata; e_we = d_we ? d_be : 4'b0000;
         end
         @(negedge clk);
         n_cmp++;
         if ({if_gnt, d_gnt, stall_fetch, m_en, if_rvalid, d_rvalid} !==
             {e_ig, e_dg, if_req && !e_ig, e_ig || e_dg, e_iv, e_dv}) begin
            n_bad++;
            $display("FAIL rand_flags c=%0d: got %b want %b", c,
                     {if_gnt, d_gnt, stall_fetch, m_en, if_rvalid, d_rvalid},
                     {e_ig, e_dg, if_req && !e_ig, e_ig || e_dg, e_iv, e_dv});
         end
         n_cmp++;
         if (m_we !== e_we || m_addr !== e_addr || m_wdata !== e_wdata) begin
            n_bad++;
            $display("FAIL rand_port c=%0d: got we=%h addr=%h wdata=%h want %h %h %h", c,
                     m_we, m_addr, m_wdata, e_we, e_addr, e_wdata);
         end
         n_cmp++;
         if (if_rdata !== e_ird || d_rdata !== e_drd) begin
            n_bad++;
            $display("FAIL rand_rdata c=%0d: got if=%h d=%h want %h %h", c,
                     if_rdata, d_rdata, e_ird, e_drd);
         end
         pend_kind = 0;
         if (e_ig) begin
            idx = if_addr[15:2];
            pend_kind = 1; pend_data = ref_mem[idx];
         end else if (e_dg) begin
            idx = d_addr[15:2];
            if (d_we) begin
               pend_kind = 3;
               for (int b = 0; b < 4; b++)
                  if (d_be[b]) ref_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
               pend_kind = 2; pend_data = ref_mem[idx];
            end
         end
         if (e_ig || !if_req) waits = 0;
         else if (e_dg && waits < SMAX) waits = waits + 1;
         d_hold = d_req && !e_dg;
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 16384; i++) begin
         v = $urandom;
         bmem[i] <= v;
         ref_mem[i] = v;
      end
      bmem[14'h2000] <= 32'h0000_0093; ref_mem[14'h2000] = 32'h0000_0093;
      bmem[14'h2400] <= 32'hDEAD_BEEF; ref_mem[14'h2400] = 32'hDEAD_BEEF;
      bmem[14'h2401] <= 32'hCAFE_F00D; ref_mem[14'h2401] = 32'hCAFE_F00D;

      test_reset();
      test_fetch_alone();
      test_collision();
      test_starvation();
      test_store();
      test_branch_kill();
      test_reset_midflight();
      test_random();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
